m_axi_burst_master: RTL and testbench

Single-outstanding AXI4 full master that turns a one-word command (direction, address, length) into one INCR burst on the master side of the AXI fabric. Write data streams in and read data streams out through valid/ready ports. It sits between the accelerator's control logic and the AXI interconnect, driving the slave ports that our AXI full slave blocks expose. One burst is in flight at a time; completion is reported with a one-cycle done pulse and a response code.

---
 rtl/m_axi_pkg.sv | 44 ++++
 rtl/m_axi_burst_master_if.sv | 58 +++++
 rtl/m_axi_burst_master.sv | 217 +++++++++++++++++++++
 tb/tb_m_axi_burst_master.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/m_axi_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst master.
package m_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] EXOKAY     = 2'b01;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] DECERR     = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // AxSIZE encodes log2 of the bytes per beat.
    function automatic logic [2:0] axsize(input int data_w);
        logic [2:0] sz;
        case (data_w)
            8:       sz = 3'd0;
            16:      sz = 3'd1;
            32:      sz = 3'd2;
            64:      sz = 3'd3;
            128:     sz = 3'd4;
            256:     sz = 3'd5;
            512:     sz = 3'd6;
            1024:    sz = 3'd7;
            default: sz = 3'd2;
        endcase
        return sz;
    endfunction

    // True when a burst starting at addr_lo with len+1 beats runs past the 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len,
                                        input int unsigned bytes);
        int unsigned end_off;
        end_off = 32'(addr_lo) + (32'(len) + 32'd1) * bytes;
        return (end_off > 32'd4096);
    endfunction

endpackage

// File: rtl/m_axi_burst_master_if.sv
// AXI4 full bus bundle between the burst master and the fabric.
interface m_axi_burst_master_if #(
    parameter int ID_W   = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/m_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master; one command in, one burst out.
// Define M_AXI_4K_CHECK_EN to reject bursts that cross a 4 KB page with SLVERR.
module m_axi_burst_master
    import m_axi_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 15
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic                          rd_last,
    output logic                          done,
    output logic [1:0]                    resp,
    m_axi_burst_master_if.master          m_axi
);

    localparam int unsigned BYTES = C_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                      len_q, len_d;
    logic [8:0]                      cnt_q, cnt_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [1:0]                      resp_q, resp_d;
    logic                            out_en_q;
    logic                            aw_hs_s, w_hs_s, last_beat_s;
    logic                            unused_s;

    assign m_axi.awid    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = axsize(C_M_AXI_DATA_WIDTH);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign m_axi.arid    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = axsize(C_M_AXI_DATA_WIDTH);
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;

    assign unused_s = ^{m_axi.bid, m_axi.rid};

    // State and burst-context registers; reset abandons any burst in flight.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            addr_q    <= {C_M_AXI_ADDR_WIDTH{1'b0}};
            len_q     <= 8'd0;
            cnt_q     <= 9'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= OKAY;
            out_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            out_en_q  <= 1'b1;
        end
    end

    // Next-state logic and channel/stream outputs for the shared FSM.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        resp_d        = resp_q;
        aw_hs_s       = 1'b0;
        w_hs_s        = 1'b0;
        last_beat_s   = 1'b0;
        cmd_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_data       = {C_M_AXI_DATA_WIDTH{1'b0}};
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        done          = 1'b0;
        resp          = OKAY;
        m_axi.awvalid = 1'b0;
        m_axi.wdata   = {C_M_AXI_DATA_WIDTH{1'b0}};
        m_axi.wlast   = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = out_en_q;
                if (cmd_valid && out_en_q) begin
                    addr_d    = cmd_addr;
                    len_d     = cmd_len;
                    cnt_d     = 9'd0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    resp_d    = OKAY;
`ifdef M_AXI_4K_CHECK_EN
                    if (crosses_4k(cmd_addr[11:0], cmd_len, BYTES)) begin
                        state_d = DONE;
                        resp_d  = SLVERR;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RADDR;
                    end
`else
                    if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RADDR;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                // AW and W progress independently; leave once both have finished.
                m_axi.awvalid = !aw_done_q;
                m_axi.wvalid  = !w_done_q && wr_valid;
                wr_ready      = !w_done_q && m_axi.wready;
                m_axi.wdata   = w_done_q ? {C_M_AXI_DATA_WIDTH{1'b0}} : wr_data;
                last_beat_s   = (cnt_q == {1'b0, len_q});
                m_axi.wlast   = !w_done_q && last_beat_s;
                aw_hs_s       = m_axi.awvalid && m_axi.awready;
                w_hs_s        = m_axi.wvalid && m_axi.wready;
                if (aw_hs_s) begin
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    cnt_d    = cnt_q + 9'd1;
                    w_done_d = last_beat_s;
                end else begin
                    cnt_d    = cnt_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || (w_hs_s && last_beat_s))) begin
                    state_d = WRESP;
                end else begin
                    state_d = WRITE;
                end
            end

            WRESP: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    state_d = DONE;
                end else begin
                    state_d = WRESP;
                end
            end

            RADDR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) begin
                    state_d = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end

            RDATA: begin
                rd_valid     = m_axi.rvalid;
                m_axi.rready = rd_ready;
                rd_data      = m_axi.rdata;
                rd_last      = m_axi.rlast;
                if (m_axi.rvalid && rd_ready) begin
                    cnt_d  = cnt_q + 9'd1;
                    // Worst response seen across all beats wins.
                    resp_d = (m_axi.rresp > resp_q) ? m_axi.rresp : resp_q;
                    if (m_axi.rlast) begin
                        state_d = DONE;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = RDATA;
                end
            end

            DONE: begin
                done    = 1'b1;
                resp    = resp_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m_axi_burst_master.sv
// Directed self-checking bench for m_axi_burst_master (honours M_AXI_4K_CHECK_EN).
module tb_m_axi_burst_master;
    import m_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [14:0] cmd_addr = 15'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [31:0] wr_data = 32'd0, rd_data;
    logic        wr_valid = 1'b0, wr_ready;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic        done;
    logic [1:0]  resp;
    int          n_checks = 0;
    int          n_fail = 0;

    m_axi_burst_master_if #(.ID_W(1), .DATA_W(32), .ADDR_W(15)) bus ();

    m_axi_burst_master #(
        .C_M_AXI_ID_WIDTH(1), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(15)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .resp(resp), .m_axi(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.bid = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0;
        bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = 1'b0;
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    // Full write burst; exp_exit is the hand-computed cycle in which BREADY first rises.
    task automatic do_write(input string tag, input logic [14:0] addr, input logic [7:0] len,
                            input int aw_cyc, input bit alt, input int exp_exit);
        int k = 0;
        int c = 0;
        int exit_c = -1;
        bit aw_seen = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len; #1;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        while (exit_c < 0 && c < 40) begin
            bus.awready = (c >= aw_cyc);
            bus.wready  = alt ? (c % 2 == 0) : 1'b1;
            wr_valid    = 1'b1;
            wr_data     = 32'hD000 + k;
            #1;
            if (bus.bready) begin
                exit_c = c;
                check({tag, "_wvalid_gated"}, bus.wvalid, 0);
                check({tag, "_awvalid_off"}, bus.awvalid, 0);
            end else begin
                check({tag, "_awvalid"}, bus.awvalid, !aw_seen);
                check({tag, "_awaddr"}, bus.awaddr, addr);
                check({tag, "_awlen"}, bus.awlen, len);
                check({tag, "_wvalid"}, bus.wvalid, (k <= len));
                check({tag, "_wr_ready"}, wr_ready, bus.wready && (k <= len));
                if (c == 0) begin
                    check({tag, "_awsize"}, bus.awsize, 3'd2);
                    check({tag, "_awburst"}, bus.awburst, 2'b01);
                    check({tag, "_wstrb"}, bus.wstrb, 4'hF);
                end
                if (bus.wvalid && bus.wready) begin
                    check({tag, "_wlast"}, bus.wlast, (k == len));
                    check({tag, "_wdata"}, bus.wdata, 32'hD000 + k);
                    k++;
                end
                if (bus.awvalid && bus.awready) aw_seen = 1'b1;
                step();
                c++;
            end
        end
        check({tag, "_exit_cycle"}, exit_c, exp_exit);
        check({tag, "_beats"}, k, len + 1);
        bus.awready = 1'b0; bus.wready = 1'b0; wr_valid = 1'b0;
        bus.bvalid = 1'b1; bus.bresp = OKAY;
        step();
        bus.bvalid = 1'b0; #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_resp"}, resp, OKAY);
        step(); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_again"}, cmd_ready, 1);
    endtask

    // Full read burst; err_beat gets RRESP=SLVERR (-1 for none).
    task automatic do_read(input string tag, input logic [14:0] addr, input logic [7:0] len,
                           input bit toggle, input int err_beat, input logic [1:0] exp_resp);
        int j = 0;
        int c = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len; #1;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0; bus.arready = 1'b0; #1;
        check({tag, "_arvalid"}, bus.arvalid, 1);
        check({tag, "_araddr"}, bus.araddr, addr);
        check({tag, "_arlen"}, bus.arlen, len);
        check({tag, "_arsize"}, bus.arsize, 3'd2);
        check({tag, "_awvalid_quiet"}, bus.awvalid, 0);
        step(); #1;
        check({tag, "_arvalid_held"}, bus.arvalid, 1);
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        while (j <= len && c < 64) begin
            rd_ready   = toggle ? (c % 2 == 1) : 1'b1;
            bus.rvalid = 1'b1;
            bus.rdata  = 32'h2000 + j;
            bus.rlast  = (j == len);
            bus.rresp  = (j == err_beat) ? SLVERR : OKAY;
            #1;
            check({tag, "_arvalid_off"}, bus.arvalid, 0);
            check({tag, "_rready"}, bus.rready, rd_ready);
            check({tag, "_rd_valid"}, rd_valid, 1);
            check({tag, "_rd_data"}, rd_data, 32'h2000 + j);
            check({tag, "_rd_last"}, rd_last, (j == len));
            check({tag, "_no_done"}, done, 0);
            if (rd_ready) j++;
            step();
            c++;
        end
        check({tag, "_beats"}, j, len + 1);
        bus.rvalid = 1'b0; bus.rlast = 1'b0; rd_ready = 1'b0; #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_resp"}, resp, exp_resp);
        step(); #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        slave_idle();
        #1 rst_n = 1'b0;
        step(); step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_done", done, 0);
        check("rst_resp", resp, 0);
        rst_n = 1'b1;
        step(); step();
        check("post_rst_cmd_ready", cmd_ready, 1);

        do_write("wr_len0", 15'h100, 8'd0, 0, 1'b0, 1);
        do_write("wr_len3_stall", 15'h180, 8'd3, 5, 1'b1, 7);
        do_read("rd_len7", 15'h200, 8'd7, 1'b1, -1, OKAY);
        do_read("rd_slverr", 15'h400, 8'd3, 1'b0, 1, SLVERR);

`ifdef M_AXI_4K_CHECK_EN
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 15'hFF8; cmd_len = 8'd3; #1;
        check("x4k_cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0; #1;
        check("x4k_no_awvalid", bus.awvalid, 0);
        check("x4k_no_wvalid", bus.wvalid, 0);
        check("x4k_done", done, 1);
        check("x4k_resp", resp, SLVERR);
        step(); #1;
        check("x4k_done_pulse", done, 0);
        check("x4k_ready_again", cmd_ready, 1);
`else
        do_write("wr_ff8", 15'hFF8, 8'd3, 0, 1'b0, 4);
`endif

        // Reset asserted while beat 2 of a 4-beat write is on the bus.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 15'h300; cmd_len = 8'd3;
        bus.awready = 1'b1; bus.wready = 1'b1; wr_valid = 1'b1; wr_data = 32'hBEEF; #1;
        step();
        cmd_valid = 1'b0; #1;
        check("mid_awvalid", bus.awvalid, 1);
        step(); step(); #1;
        check("mid_beat2_wvalid", bus.wvalid, 1);
        check("mid_beat2_wlast", bus.wlast, 0);
        rst_n = 1'b0; #1;
        check("mid_rst_awvalid", bus.awvalid, 0);
        check("mid_rst_wvalid", bus.wvalid, 0);
        check("mid_rst_wlast", bus.wlast, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_bready", bus.bready, 0);
        check("mid_rst_arvalid", bus.arvalid, 0);
        check("mid_rst_rready", bus.rready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_resp", resp, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        step(); step();
        slave_idle();
        rst_n = 1'b1;
        step(); step(); #1;
        check("mid_release_cmd_ready", cmd_ready, 1);
        check("mid_release_awvalid", bus.awvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
